// File: rtl/irq_ctrl_vec_if.sv
// CPU-side bus of the vectored interrupt controller: intr/inta/eoi handshake plus
// the mask write port and the mask/pending status readback.
interface irq_ctrl_vec_if #(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned VEC_W   = 3
);
  logic               intr;
  logic               inta;
  logic [VEC_W-1:0]   vector;
  logic               eoi;
  logic               busy;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wd;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] pend;

  modport master (
    input  intr, vector, busy, mask, pend,
    output inta, eoi, mask_we, mask_wd
  );

  modport slave (
    output intr, vector, busy, mask, pend,
    input  inta, eoi, mask_we, mask_wd
  );
endinterface

// File: rtl/irq_ctrl_vec.sv
// Vectored interrupt controller: edge/level request latching, masking, fixed priority
// (channel 0 highest), single in-service tracking. Define IRQ_SYNC_EN for input synchronisers.
module irq_ctrl_vec #(
  parameter int unsigned        NUM_IRQ  = 8,
  parameter int unsigned        VEC_W    = 3,
  parameter logic [NUM_IRQ-1:0] MASK_RST = '0
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] edge_mode,
  irq_ctrl_vec_if.slave      bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StSvc  = 2'd2;

  if ((2 ** VEC_W) < NUM_IRQ) begin : g_bad_vec_w
    $error("VEC_W too narrow for NUM_IRQ");
  end

  logic [NUM_IRQ-1:0] irq_s;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  logic [1:0]         state_q, state_d;
  logic [VEC_W-1:0]   vector_q, vector_d;
  logic [NUM_IRQ-1:0] prev_q, pend_q, pend_d, mask_q, mask_d;
  logic [NUM_IRQ-1:0] rise, eligible, clr;
  logic [VEC_W-1:0]   sel;
  logic               found;
  logic               ack;

  assign ack = (state_q == StReq) && bus.inta;

  always_comb begin
    rise     = irq_s & ~prev_q;
    eligible = pend_q & ~mask_q;
    sel      = '0;
    found    = 1'b0;
    clr      = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (eligible[i] && !found) begin
        sel   = VEC_W'(i);
        found = 1'b1;
      end
      clr[i] = ack && edge_mode[i] && (vector_q == VEC_W'(i));
    end
    // Edge bits: a new rise beats a same-cycle acknowledge clear.
    pend_d = (edge_mode & (rise | (pend_q & ~clr))) | (~edge_mode & irq_s);
    mask_d = bus.mask_we ? bus.mask_wd : mask_q;
  end

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d  = StReq;
          vector_d = sel;
        end
      end
      StReq:   if (bus.inta) state_d = StSvc;
      StSvc:   if (bus.eoi) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= StIdle;
      vector_q <= '0;
      prev_q   <= '0;
      pend_q   <= '0;
      mask_q   <= MASK_RST;
    end else begin
      state_q  <= state_d;
      vector_q <= vector_d;
      prev_q   <= irq_s;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
    end
  end

  assign bus.intr   = (state_q == StReq);
  assign bus.busy   = (state_q == StSvc);
  assign bus.vector = vector_q;
  assign bus.mask   = mask_q;
  assign bus.pend   = pend_q;

endmodule

// File: tb/tb_irq_ctrl_vec.sv
// Self-checking bench for irq_ctrl_vec: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_irq_ctrl_vec;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] irq_in;
  logic [7:0] edge_mode;

  irq_ctrl_vec_if #(.NUM_IRQ(8), .VEC_W(3)) bus ();

  irq_ctrl_vec #(.NUM_IRQ(8), .VEC_W(3), .MASK_RST(8'h00)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .irq_in    (irq_in),
    .edge_mode (edge_mode),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, got, exp);
    end
  endtask

  // Behavioural model: state 0 = idle, 1 = requesting, 2 = in service.
  int         m_st;
  logic [7:0] m_pend, m_mask, m_prev, m_s1, m_s2;
  logic [2:0] m_vec;

  task automatic model_reset();
    m_st = 0; m_pend = 0; m_mask = 0; m_prev = 0; m_s1 = 0; m_s2 = 0; m_vec = 0;
  endtask

  task automatic model_step(input logic [7:0] irq, input logic [7:0] em, input logic we,
                            input logic [7:0] wd, input logic ia, input logic eo);
    logic [7:0] s, rise, elig, clr, oh;
`ifdef IRQ_SYNC_EN
    s = m_s2; m_s2 = m_s1; m_s1 = irq;
`else
    s = irq;
`endif
    rise   = s & ~m_prev;
    m_prev = s;
    elig   = m_pend & ~m_mask;
    clr    = (m_st == 1 && ia && em[m_vec]) ? 8'(1 << m_vec) : 8'h00;
    m_pend = (em & (rise | (m_pend & ~clr))) | (~em & s);
    if (we) m_mask = wd;
    case (m_st)
      0: if (elig != 0) begin
        oh    = elig & (~elig + 8'd1);
        m_vec = 3'($clog2(oh));
        m_st  = 1;
      end
      1: if (ia) m_st = 2;
      default: if (eo) m_st = 0;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!clrn) model_reset();
      else model_step(irq_in, edge_mode, bus.mask_we, bus.mask_wd, bus.inta, bus.eoi);
      #2;
      check("intr",   32'(bus.intr),   32'(m_st == 1));
      check("busy",   32'(bus.busy),   32'(m_st == 2));
      check("vector", 32'(bus.vector), 32'(m_vec));
      check("pend",   32'(bus.pend),   32'(m_pend));
      check("mask",   32'(bus.mask),   32'(m_mask));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_inta();
    bus.inta = 1'b1; @(negedge clk); bus.inta = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.eoi = 1'b1; @(negedge clk); bus.eoi = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] m);
    bus.mask_we = 1'b1; bus.mask_wd = m; @(negedge clk); bus.mask_we = 1'b0;
  endtask

  task automatic wait_intr(input string name, input int budget);
    int n = 0;
    while (bus.intr !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.intr), 32'd1);
  endtask

  initial begin
    clrn = 1'b0; irq_in = 8'h00; edge_mode = 8'hFD;
    bus.inta = 1'b0; bus.eoi = 1'b0; bus.mask_we = 1'b0; bus.mask_wd = 8'h00;
    step(2);
    check("rst_intr", 32'(bus.intr), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_pend", 32'(bus.pend), 0);
    check("rst_mask", 32'(bus.mask), 0);
    clrn = 1'b1;
    step(2);

    // Single edge request on channel 3, exact latency.
    irq_in[3] = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1 check("lat_early_intr", 32'(bus.intr), 0);
    @(posedge clk);
    #1 check("lat_intr", 32'(bus.intr), 1);
    check("lat_vector", 32'(bus.vector), 3);
    @(negedge clk);
    irq_in[3] = 1'b0;
    pulse_inta();
    check("ack_intr", 32'(bus.intr), 0);
    check("ack_busy", 32'(bus.busy), 1);
    check("ack_pend3", 32'(bus.pend[3]), 0);
    pulse_eoi();
    check("eoi_busy", 32'(bus.busy), 0);
    check("eoi_intr", 32'(bus.intr), 0);

    // Two simultaneous edges: priority order 2 then 5.
    irq_in[5] = 1'b1; irq_in[2] = 1'b1;
    wait_intr("prio_wait_a", 10);
    check("prio_first", 32'(bus.vector), 2);
    irq_in[5] = 1'b0; irq_in[2] = 1'b0;
    pulse_inta();
    pulse_eoi();
    wait_intr("prio_wait_b", 10);
    check("prio_second", 32'(bus.vector), 5);
    pulse_inta();
    pulse_eoi();

    // Level channel 1 held high re-requests one cycle after eoi.
    irq_in[1] = 1'b1;
    wait_intr("lvl_wait", 10);
    check("lvl_vector", 32'(bus.vector), 1);
    pulse_inta();
    check("lvl_pend_svc", 32'(bus.pend[1]), 1);
    pulse_eoi();
    check("lvl_idle", 32'(bus.intr), 0);
    step(1);
    check("lvl_rereq", 32'(bus.intr), 1);
    check("lvl_rereq_vec", 32'(bus.vector), 1);
    irq_in[1] = 1'b0;
    step(4);
    pulse_inta();
    pulse_eoi();
    step(6);
    check("lvl_dropped", 32'(bus.intr), 0);

    // Masked channel 4 stays pending until unmasked.
    write_mask(8'h10);
    check("mask_written", 32'(bus.mask), 32'h10);
    irq_in[4] = 1'b1; step(2); irq_in[4] = 1'b0;
    step(6);
    check("masked_intr", 32'(bus.intr), 0);
    check("masked_pend", 32'(bus.pend), 32'h10);
    write_mask(8'h00);
    wait_intr("unmask_wait", 6);
    check("unmask_vector", 32'(bus.vector), 4);
    pulse_inta();
    pulse_eoi();

    // No retraction: mask channel 6 and raise channel 0 during its request.
    irq_in[6] = 1'b1;
    wait_intr("noretract_wait", 10);
    check("noretract_vec6", 32'(bus.vector), 6);
    irq_in[6] = 1'b0; irq_in[0] = 1'b1;
    write_mask(8'h40);
    step(5);
    check("noretract_intr", 32'(bus.intr), 1);
    check("noretract_vec", 32'(bus.vector), 6);
    pulse_inta();
    irq_in[0] = 1'b0;
    pulse_eoi();
    wait_intr("ch0_wait", 6);
    check("ch0_vector", 32'(bus.vector), 0);
    pulse_inta();
    pulse_eoi();
    write_mask(8'h00);

    // Asynchronous reset during service with pend = 8'h81.
    irq_in[7] = 1'b1;
    wait_intr("rst_mid_wait", 10);
    check("rst_mid_vec", 32'(bus.vector), 7);
    pulse_inta();
    irq_in[7] = 1'b0;
    step(3);
    irq_in = 8'h81;
    step(LAT + 1);
    write_mask(8'h02);
    check("pre_rst_busy", 32'(bus.busy), 1);
    check("pre_rst_pend", 32'(bus.pend), 32'h81);
    #3 clrn = 1'b0;
    #1;
    check("mid_rst_intr", 32'(bus.intr), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_pend", 32'(bus.pend), 0);
    check("mid_rst_vector", 32'(bus.vector), 0);
    check("mid_rst_mask", 32'(bus.mask), 0);
    irq_in = 8'h00;
    step(1);
    clrn = 1'b1;
    step(2);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      irq_in   = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(199) == 0) edge_mode = 8'($urandom);
      bus.inta    = ($urandom_range(3) == 0);
      bus.eoi     = ($urandom_range(3) == 0);
      bus.mask_we = ($urandom_range(15) == 0);
      bus.mask_wd = 8'($urandom) & 8'($urandom);
      clrn        = ($urandom_range(399) != 0);
      @(negedge clk);
    end
    clrn = 1'b1; bus.inta = 1'b0; bus.eoi = 1'b0; bus.mask_we = 1'b0;
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
